riscv_cpu: RTL and testbench
============================

Name: riscv_cpu

Overview:
- Single-cycle RV32I-subset processor core: one instruction fetched, decoded, executed and retired per clock.
- Contains instruction memory, a 32x32 register file, an ALU, a control unit and a word-addressed data memory.
- No external bus. Program and initial register values are loaded by hierarchical backdoor access from the bench.
- Top-level building block for the CPU project.

Parameters:
- IMEM_WORDS, 256, depth of instruction memory in 32-bit words.
- DMEM_WORDS, 256, depth of data memory in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value loaded while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).

Behaviour:
- Hierarchy, required for bench backdoor access:
  - Fetch instance named IF, containing reg [31:0] pc and array memory[0:IMEM_WORDS-1].
  - Register-file instance named RF, containing array registers[0:31].
- Reset (reset=0, asynchronous):
  - pc <= RESET_PC.
  - All registers <= 0.
  - Instruction and data memories are not cleared.
- Fetch: instruction = IF.memory[pc[31:2]], combinational. pc is always word aligned.
- Each rising edge with reset=1: pc <= next_pc, and a register write occurs if enabled. Architectural state is committed one edge after the PC points at the instruction.
- next_pc = pc+4, except for taken branches and JAL.
- Register file:
  - Two combinational read ports.
  - One synchronous write port.
  - x0 reads 0 and writes to x0 are discarded.
  - Reads see the old value in the same cycle.
- Supported opcodes:
  - 0110011 R-type:
    - funct3/funct7 select ADD, SUB (funct7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA (funct7=0100000), OR, AND.
    - Shifts use rs2[4:0].
  - 0010011 I-type: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. imm is sign-extended from [31:20]; shift amount is [24:20].
  - 0000011 load: LW only (funct3 ignored). rd <= dmem[(rs1+imm)[31:2]].
  - 0100011 store:
    - Full-word store regardless of funct3.
    - imm = sext({[31:25],[11:7]}).
    - dmem[(rs1+imm)[31:2]] <= rs2 on the clock edge.
    - No register write.
  - 1100011 branch: BEQ (funct3 000), BNE (001). Target = pc + sext({[31],[7],[30:25],[11:8],1'b0}). Other funct3 values are not taken.
  - 1101111 JAL: rd <= pc+4; pc <= pc + sext J-immediate.
  - 0110111 LUI: rd <= {imm[31:12],12'b0}.
- Any other opcode, including all-zero 32'h0000_0000: treated as NOP. No register or memory write; pc <= pc+4.
- Arithmetic: 32-bit, wrap-around, no overflow flags. SLT is signed; SLTU is unsigned.
- Memory index out of range: only low log2(depth) index bits are used (wrap).
- reset asserted mid-program: pc and registers clear immediately; memories are retained.

Test Plan:
- Reset and release: reset=0 then 1. pc=0 while reset=0, all registers 0; pc advances by 4 each clock afterwards.
- ALU chain:
  - Load x1=1, x2=2.
  - imem[0]=ADD x3,x1,x2 (32'h002081B3), imem[1]=ADD x4,x3,x1 (32'h00118233), imem[2]=32'h0, imem[3]=store of x4 at x3-relative address.
  - Required: x3=3, x4=4 after 10 cycles; the NOP changes no register; pc passes 0,4,8,12.
- Store/load: SW x4,4(x3) then LW x5,4(x3) with x3=0, x4=32'hDEADBEEF -> dmem[1]=DEADBEEF, x5=DEADBEEF.
- Branch: x1=x2=5, BEQ x1,x2,+8 at pc=0 -> next pc=8. With BNE instead -> next pc=4.
- x0 and immediates:
  - ADDI x0,x0,7 -> x0 stays 0.
  - ADDI x6,x0,-1 -> x6=FFFFFFFF.
  - SLTU x7,x0,x6 -> 1; SLT x7,x6,x0 -> 1; SRA of 80000000 by 4 -> F8000000.
- Async reset mid-run: assert reset=0 between edges with pc=12 -> pc=0 and registers 0 without waiting for a clock edge; memories keep contents.

Source files
------------

// File: rtl/riscv_cpu.sv
// Single-cycle RV32I-subset core: fetch, decode, execute and retire one instruction per clock.
// Latency: architectural state (pc, rd, dmem) commits on the rising edge that ends the instruction's cycle.
// Backpressure: none; no external bus, the core free-runs whenever reset is deasserted.

// Fetch unit: program counter and instruction memory with a combinational read.
module riscv_fetch #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   pc_d_i,
  input  logic                          imem_we_i,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr_i,
  input  logic [31:0]                   imem_wdata_i,
  output logic [31:0]                   pc_o,
  output logic [31:0]                   instr_o
);
  localparam int IAW = $clog2(IMEM_WORDS);

  logic [31:0] pc;
  logic [31:0] memory [0:IMEM_WORDS-1];
  logic        unused_pc_bits;

  // Program counter: cleared to the reset vector asynchronously, otherwise follows next-pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_d_i;
  end

  // Loader write port; the core ties it off and programs arrive by backdoor.
  always_ff @(posedge clk) begin
    if (imem_we_i) memory[imem_waddr_i] <= imem_wdata_i;
  end

  // Out-of-range pcs wrap onto the low index bits; pc is always word aligned.
  assign instr_o        = memory[pc[IAW+1:2]];
  assign pc_o           = pc;
  assign unused_pc_bits = ^{pc[31:IAW+2], pc[1:0]};
endmodule

// Register file: 32x32, two combinational read ports, one synchronous write port, x0 hardwired to zero.
module riscv_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_we_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o
);
  logic [31:0] registers [0:31];

  // Clear every register on reset; writes to x0 are dropped so it never holds a non-zero value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) registers[i] <= 32'h0;
    end else if (rd_we_i && (rd_addr_i != 5'd0)) begin
      registers[rd_addr_i] <= rd_data_i;
    end
  end

  // Reads return the pre-edge value, so an instruction reading its own rd sees the old contents.
  assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'h0 : registers[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'h0 : registers[rs2_addr_i];
endmodule

module riscv_cpu #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset
);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [31:0] pc, pc_d, pc_plus4, instr;
  logic [31:0] rs1_dat, rs2_dat, rf_wdat, alu_b, alu_res;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, ls_addr, dmem_rdat;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        rf_we, dmem_we, is_alt, unused_addr_bits;
  logic [31:0] dmem [0:DMEM_WORDS-1];

  riscv_fetch #(.IMEM_WORDS(IMEM_WORDS), .RESET_PC(RESET_PC)) IF (
    .clk          (clk),
    .rst_n        (reset),
    .pc_d_i       (pc_d),
    .imem_we_i    (1'b0),
    .imem_waddr_i ('0),
    .imem_wdata_i (32'h0),
    .pc_o         (pc),
    .instr_o      (instr)
  );

  riscv_regfile RF (
    .clk        (clk),
    .rst_n      (reset),
    .rs1_addr_i (instr[19:15]),
    .rs2_addr_i (instr[24:20]),
    .rd_addr_i  (instr[11:7]),
    .rd_data_i  (rf_wdat),
    .rd_we_i    (rf_we),
    .rs1_data_o (rs1_dat),
    .rs2_data_o (rs2_dat)
  );

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign is_alt   = (funct7 == 7'b0100000);
  assign pc_plus4 = pc + 32'd4;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};

  // Loads and stores share one word-index adder; out-of-range indices wrap.
  assign ls_addr          = rs1_dat + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign dmem_rdat        = dmem[ls_addr[DAW+1:2]];
  assign unused_addr_bits = ^{ls_addr[31:DAW+2], ls_addr[1:0]};

  // ALU: R-type takes rs2, I-type takes imm_i (whose low 5 bits double as shamt). SUB only exists for R-type.
  always_comb begin
    alu_b   = (opcode == OP_R) ? rs2_dat : imm_i;
    alu_res = 32'h0;
    case (funct3)
      3'b000: alu_res = ((opcode == OP_R) && is_alt) ? rs1_dat - alu_b : rs1_dat + alu_b;
      3'b001: alu_res = rs1_dat << alu_b[4:0];
      3'b010: alu_res = {31'h0, $signed(rs1_dat) < $signed(alu_b)};
      3'b011: alu_res = {31'h0, rs1_dat < alu_b};
      3'b100: alu_res = rs1_dat ^ alu_b;
      3'b101: alu_res = is_alt ? $unsigned($signed(rs1_dat) >>> alu_b[4:0]) : rs1_dat >> alu_b[4:0];
      3'b110: alu_res = rs1_dat | alu_b;
      3'b111: alu_res = rs1_dat & alu_b;
    endcase
  end

  // Control: pick next pc, writeback source and enables; unknown opcodes fall through as NOPs.
  always_comb begin
    pc_d    = pc_plus4;
    rf_we   = 1'b0;
    rf_wdat = alu_res;
    dmem_we = 1'b0;
    case (opcode)
      OP_R, OP_I: rf_we = 1'b1;
      OP_LOAD: begin
        rf_we   = 1'b1;
        rf_wdat = dmem_rdat;
      end
      OP_STORE: dmem_we = 1'b1;
      OP_BRANCH: begin
        if (((funct3 == 3'b000) && (rs1_dat == rs2_dat)) ||
            ((funct3 == 3'b001) && (rs1_dat != rs2_dat))) pc_d = pc + imm_b;
      end
      OP_JAL: begin
        rf_we   = 1'b1;
        rf_wdat = pc_plus4;
        pc_d    = pc + imm_j;
      end
      OP_LUI: begin
        rf_we   = 1'b1;
        rf_wdat = imm_u;
      end
      default: ;
    endcase
  end

  // Data memory: full-word store on the edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (dmem_we) dmem[ls_addr[DAW+1:2]] <= rs2_dat;
  end
endmodule

// File: tb/tb_riscv_cpu.sv
// Scoreboard bench for riscv_cpu: directed programs loaded by backdoor, expectations queued at issue time.
// Latency: checks are pushed one step after the edge they follow and compared at the next sample point.
// Backpressure: none; the monitor drains the whole queue at every sample point.
module tb_riscv_cpu;
  logic clk;
  logic reset;

  riscv_cpu dut (.clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = pc, 1 = register, 2 = dmem word, 3 = imem word
  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event kick;

  task automatic push_exp(input string nm, input int k, input int i, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.kind = k; e.idx = i; e.exp = v;
    sb_q.push_back(e);
  endtask

  // Monitor: samples DUT state at every falling edge, or immediately when kicked.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk or kick);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.kind)
          0:       act = dut.IF.pc;
          1:       act = dut.RF.registers[e.idx];
          2:       act = dut.dmem[e.idx];
          default: act = dut.IF.memory[e.idx];
        endcase
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  // Hold reset, wipe memories; the caller then loads program/registers and calls go() before the next rising edge.
  task automatic begin_load();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) begin
      dut.IF.memory[i] = 32'h0;
      dut.dmem[i]      = 32'h0;
    end
  endtask

  task automatic go();
    reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic branch_case(input string nm, input logic [31:0] ins, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_pc);
    begin_load();
    dut.IF.memory[0]       = ins;
    dut.RF.registers[1]    = a;
    dut.RF.registers[2]    = b;
    go();
    step(1);
    push_exp(nm, 0, 0, exp_pc);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    push_exp("reset_pc", 0, 0, 32'h0);
    for (int r = 0; r < 32; r++) push_exp($sformatf("reset_x%0d", r), 1, r, 32'h0);

    // Release with an all-NOP program: pc steps by 4.
    begin_load();
    go();
    step(1); push_exp("release_pc1", 0, 0, 32'd4);
    step(2); push_exp("release_pc3", 0, 0, 32'd12);

    // ALU chain with a NOP and a store of x4 at address x3+0.
    begin_load();
    dut.RF.registers[1] = 32'd1;
    dut.RF.registers[2] = 32'd2;
    dut.IF.memory[0] = 32'h002081B3;
    dut.IF.memory[1] = 32'h00118233;
    dut.IF.memory[2] = 32'h00000000;
    dut.IF.memory[3] = 32'h0041A023;
    go();
    for (int c = 1; c <= 10; c++) begin
      step(1);
      push_exp($sformatf("chain_pc%0d", c), 0, 0, 32'(4 * c));
      if (c == 1) push_exp("chain_x3", 1, 3, 32'd3);
      if (c == 2) push_exp("chain_x4", 1, 4, 32'd4);
      if (c == 3) begin
        push_exp("nop_x3", 1, 3, 32'd3);
        push_exp("nop_x4", 1, 4, 32'd4);
        push_exp("nop_x5", 1, 5, 32'd0);
      end
      if (c == 4) push_exp("chain_store", 2, 0, 32'd4);
    end
    push_exp("chain_x3_end", 1, 3, 32'd3);
    push_exp("chain_x4_end", 1, 4, 32'd4);

    // SW x4,4(x3) then LW x5,4(x3).
    begin_load();
    dut.RF.registers[4] = 32'hDEADBEEF;
    dut.IF.memory[0] = 32'h0041A223;
    dut.IF.memory[1] = 32'h0041A283;
    go();
    step(2);
    push_exp("sw_dmem1", 2, 1, 32'hDEADBEEF);
    push_exp("lw_x5", 1, 5, 32'hDEADBEEF);

    // Branches: BEQ/BNE x1,x2,+8 with equal and unequal operands.
    branch_case("beq_taken",    32'h00208463, 32'd5, 32'd5, 32'd8);
    branch_case("bne_nottaken", 32'h00209463, 32'd5, 32'd5, 32'd4);
    branch_case("beq_nottaken", 32'h00208463, 32'd5, 32'd6, 32'd4);
    branch_case("bne_taken",    32'h00209463, 32'd5, 32'd6, 32'd8);

    // JAL x1,+16 then LUI x2,0x12345 at the target.
    begin_load();
    dut.IF.memory[0] = 32'h010000EF;
    dut.IF.memory[4] = 32'h12345137;
    go();
    step(1);
    push_exp("jal_pc", 0, 0, 32'd16);
    push_exp("jal_link", 1, 1, 32'd4);
    step(1);
    push_exp("lui_x2", 1, 2, 32'h12345000);
    push_exp("lui_pc", 0, 0, 32'd20);

    // x0 protection, immediates, signed/unsigned compares, shifts, SUB.
    begin_load();
    dut.RF.registers[9]  = 32'h80000000;
    dut.RF.registers[10] = 32'd4;
    dut.IF.memory[0] = 32'h00700013; // ADDI x0,x0,7
    dut.IF.memory[1] = 32'hFFF00313; // ADDI x6,x0,-1
    dut.IF.memory[2] = 32'h006033B3; // SLTU x7,x0,x6
    dut.IF.memory[3] = 32'h00032433; // SLT  x8,x6,x0
    dut.IF.memory[4] = 32'h40A4D5B3; // SRA  x11,x9,x10
    dut.IF.memory[5] = 32'h00A4D633; // SRL  x12,x9,x10
    dut.IF.memory[6] = 32'h406506B3; // SUB  x13,x10,x6
    go();
    step(7);
    push_exp("x0_stays_0", 1, 0, 32'h0);
    push_exp("addi_neg1", 1, 6, 32'hFFFFFFFF);
    push_exp("sltu", 1, 7, 32'd1);
    push_exp("slt", 1, 8, 32'd1);
    push_exp("sra", 1, 11, 32'hF8000000);
    push_exp("srl", 1, 12, 32'h08000000);
    push_exp("sub", 1, 13, 32'd5);

    // Async reset between edges at pc=12: state clears at once, memories persist.
    begin_load();
    dut.RF.registers[1] = 32'd1;
    dut.RF.registers[2] = 32'd2;
    dut.IF.memory[0] = 32'h002081B3;
    dut.IF.memory[1] = 32'h00118233;
    dut.IF.memory[3] = 32'h0041A023;
    dut.dmem[5]      = 32'hCAFEF00D;
    go();
    step(3);
    push_exp("pre_rst_pc", 0, 0, 32'd12);
    push_exp("pre_rst_x4", 1, 4, 32'd4);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    push_exp("async_pc", 0, 0, 32'h0);
    push_exp("async_x1", 1, 1, 32'h0);
    push_exp("async_x3", 1, 3, 32'h0);
    push_exp("async_x4", 1, 4, 32'h0);
    push_exp("keep_imem1", 3, 1, 32'h00118233);
    push_exp("keep_dmem5", 2, 5, 32'hCAFEF00D);
    -> kick;

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
